pipe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 16-bit, 4-stage-after-decode core (ID, EX, MEM, WB).
- Detects read-after-write hazards on the decode-stage instruction using a 3-slot in-flight scoreboard.
- Inserts bubbles, flushes on taken branches, freezes the pipe on data-memory wait, and provides debug halt/single-step.
- Sits beside the decode stage and drives the PC, IF/ID and ID/EX register enables.

---
 rtl/pipe_hazard_ctrl_if.sv | 35 +++
 rtl/pipe_hazard_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the decode-side pipeline and the hazard/sequencing controller.
// The pipeline side uses the master modport and the controller uses the slave modport.
interface pipe_hazard_ctrl_if;
  logic [15:0] id_inst_i;
  logic        id_valid_i;
  logic        ex_br_taken_i;
  logic [6:0]  ex_br_target_i;
  logic        mem_req_i;
  logic        mem_ready_i;
  logic        dbg_halt_i;
  logic        dbg_step_i;

  logic        stall_o;
  logic        bubble_o;
  logic        flush_o;
  logic        pc_load_o;
  logic [6:0]  pc_target_o;
  logic        freeze_o;
  logic        halted_o;
  logic [15:0] stall_cnt_o;

  modport master (
    output id_inst_i, id_valid_i, ex_br_taken_i, ex_br_target_i,
           mem_req_i, mem_ready_i, dbg_halt_i, dbg_step_i,
    input  stall_o, bubble_o, flush_o, pc_load_o, pc_target_o,
           freeze_o, halted_o, stall_cnt_o
  );

  modport slave (
    input  id_inst_i, id_valid_i, ex_br_taken_i, ex_br_target_i,
           mem_req_i, mem_ready_i, dbg_halt_i, dbg_step_i,
    output stall_o, bubble_o, flush_o, pc_load_o, pc_target_o,
           freeze_o, halted_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: RAW hazard scoreboard, branch flush,
// data-memory freeze and debug halt/single-step for the ID/EX/MEM/WB core.
module pipe_hazard_ctrl #(
  parameter bit         FWD_EN  = 1'b1,
  parameter logic [3:0] NOP_OP  = 4'h0,
  parameter logic [3:0] ADDI_OP = 4'h1,
  parameter logic [3:0] LD_OP   = 4'h8,
  parameter logic [3:0] BNE_OP  = 4'hB,
  parameter logic [3:0] BLT_OP  = 4'hC
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    MEMW   = 2'd1,
    HALTED = 2'd2,
    STEP   = 2'd3
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] rd;
    logic       is_load;
  } slot_t;

  state_t state;
  state_t state_next;

  slot_t ex_slot;
  slot_t mem_slot;
  slot_t wb_slot;
  slot_t issue_slot;

  logic [3:0]  opcode;
  logic [2:0]  rd;
  logic [2:0]  rs;
  logic        use_rd;
  logic        use_rs;
  logic        writes;
  logic        is_load;

  logic        ex_match;
  logic        mem_match;
  logic        hazard;
  logic        mem_wait;
  logic        freeze;
  logic        flush;
  logic        stall;
  logic [15:0] stall_cnt;

  function automatic logic slot_match(slot_t s, logic ur, logic [2:0] a,
                                      logic us, logic [2:0] b);
    return s.valid & ((ur & (s.rd == a)) | (us & (s.rd == b)));
  endfunction

  always_comb begin
    opcode  = bus.id_inst_i[3:0];
    rd      = bus.id_inst_i[6:4];
    rs      = bus.id_inst_i[9:7];
    use_rd  = 1'b1;
    use_rs  = 1'b1;
    writes  = 1'b1;
    is_load = 1'b0;
    case (opcode)
      NOP_OP: begin
        use_rd = 1'b0;
        use_rs = 1'b0;
        writes = 1'b0;
      end
      ADDI_OP: use_rs = 1'b0;
      LD_OP: begin
        use_rd  = 1'b0;
        is_load = 1'b1;
      end
      BNE_OP, BLT_OP: writes = 1'b0;
      default: ;
    endcase
  end

  // WB results are visible to decode in the same cycle, so only EX and MEM can hazard.
  assign ex_match  = slot_match(ex_slot,  use_rd, rd, use_rs, rs);
  assign mem_match = slot_match(mem_slot, use_rd, rd, use_rs, rs);
  assign hazard    = FWD_EN ? (ex_match & ex_slot.is_load) : (ex_match | mem_match);

  assign mem_wait = bus.mem_req_i & ~bus.mem_ready_i;
  assign freeze   = ((state == RUN) & mem_wait) | (state == MEMW) | (state == HALTED);
  assign flush    = bus.ex_br_taken_i & ~freeze;
  assign stall    = bus.id_valid_i & hazard & ~flush & ~freeze;

  always_comb begin
    issue_slot.valid   = bus.id_valid_i & ~stall & ~flush & writes;
    issue_slot.rd      = rd;
    issue_slot.is_load = is_load;
  end

  assign bus.stall_o     = stall;
  assign bus.bubble_o    = stall | flush;
  assign bus.flush_o     = flush;
  assign bus.pc_load_o   = flush;
  assign bus.pc_target_o = flush ? bus.ex_br_target_i : 7'h00;
  assign bus.freeze_o    = freeze;
  assign bus.halted_o    = (state == HALTED);
  assign bus.stall_cnt_o = stall_cnt;

  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (mem_wait)
          state_next = MEMW;
        else if (bus.dbg_halt_i)
          state_next = HALTED;
      end
      MEMW: begin
        if (bus.mem_ready_i)
          state_next = bus.dbg_halt_i ? HALTED : RUN;
      end
      HALTED: begin
        if (!bus.dbg_halt_i)
          state_next = RUN;
        else if (bus.dbg_step_i)
          state_next = STEP;
      end
      STEP: begin
        if (mem_wait)
          state_next = MEMW;
        else
          state_next = bus.dbg_halt_i ? HALTED : RUN;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= RUN;
    else
      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_slot  <= '0;
      mem_slot <= '0;
      wb_slot  <= '0;
    end else if (!freeze) begin
      ex_slot  <= issue_slot;
      mem_slot <= ex_slot;
      wb_slot  <= mem_slot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= 16'h0000;
    else if ((stall | freeze) && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end

  // The WB slot and MEM load flag are tracked for completeness but never feed a hazard.
  logic unused_ok;
  assign unused_ok = ^{bus.id_inst_i[15:10], mem_slot.is_load, wb_slot};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: directed vector table, reset sequence, then random stimulus
// compared against a behavioural model, for both forwarding configurations.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if bus1();
  pipe_hazard_ctrl_if bus0();

  pipe_hazard_ctrl #(.FWD_EN(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  pipe_hazard_ctrl #(.FWD_EN(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  int checks = 0;
  int passes = 0;

  typedef struct packed {
    logic [15:0] inst;
    logic        valid;
    logic        br;
    logic [6:0]  tgt;
    logic        req;
    logic        rdy;
    logic        halt;
    logic        step;
    logic        s1;
    logic        s0;
    logic        flush;
    logic        frz;
    logic        hlt;
    logic [15:0] cnt1;
    logic [15:0] cnt0;
  } vec_t;

  typedef struct {
    bit valid;
    int dest;
    bit load;
  } flight_t;

  vec_t vecs[25];

  flight_t fl1[$];
  flight_t fl0[$];
  bit m_wait, m_halt, m_step;
  int cnt1, cnt0;

  task automatic applyStimulus(input logic [15:0] inst, input logic valid, input logic br,
                               input logic [6:0] tgt, input logic req, input logic rdy,
                               input logic halt, input logic step);
    bus1.id_inst_i = inst;  bus0.id_inst_i = inst;
    bus1.id_valid_i = valid; bus0.id_valid_i = valid;
    bus1.ex_br_taken_i = br; bus0.ex_br_taken_i = br;
    bus1.ex_br_target_i = tgt; bus0.ex_br_target_i = tgt;
    bus1.mem_req_i = req;   bus0.mem_req_i = req;
    bus1.mem_ready_i = rdy; bus0.mem_ready_i = rdy;
    bus1.dbg_halt_i = halt; bus0.dbg_halt_i = halt;
    bus1.dbg_step_i = step; bus0.dbg_step_i = step;
  endtask

  task automatic checkOutput(input string name, input logic [28:0] got, input logic [28:0] exp);
    checks++;
    if (got === exp)
      passes++;
    else
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  // Output bundle order: stall, bubble, flush, pc_load, pc_target, freeze, halted, stall_cnt.
  function automatic logic [28:0] mkExp(logic s, logic fl, logic [6:0] tgt, logic frz,
                                        logic hlt, logic [15:0] cnt);
    return {s, s | fl, fl, fl, (fl ? tgt : 7'h00), frz, hlt, cnt};
  endfunction

  function automatic logic [28:0] got1();
    return {bus1.stall_o, bus1.bubble_o, bus1.flush_o, bus1.pc_load_o, bus1.pc_target_o,
            bus1.freeze_o, bus1.halted_o, bus1.stall_cnt_o};
  endfunction

  function automatic logic [28:0] got0();
    return {bus0.stall_o, bus0.bubble_o, bus0.flush_o, bus0.pc_load_o, bus0.pc_target_o,
            bus0.freeze_o, bus0.halted_o, bus0.stall_cnt_o};
  endfunction

  // Registers an instruction reads, as a bitmask over r0..r7.
  function automatic int srcMask(logic [15:0] inst);
    int rdb, rsb;
    rdb = 1 << int'(inst[6:4]);
    rsb = 1 << int'(inst[9:7]);
    case (inst[3:0])
      4'h0:       return 0;
      4'h1:       return rdb;
      4'h8:       return rsb;
      default:    return rdb | rsb;
    endcase
  endfunction

  function automatic bit writesReg(logic [15:0] inst);
    return !(inst[3:0] == 4'h0 || inst[3:0] == 4'hB || inst[3:0] == 4'hC);
  endfunction

  task automatic modelReset();
    flight_t e;
    e.valid = 0; e.dest = 0; e.load = 0;
    fl1 = {e, e, e};
    fl0 = {e, e, e};
    m_wait = 0; m_halt = 0; m_step = 0;
    cnt1 = 0; cnt0 = 0;
  endtask

  task automatic modelCycle(input logic [15:0] inst, input logic valid, input logic br,
                            input logic [6:0] tgt, input logic req, input logic rdy,
                            input logic halt, input logic step,
                            output logic [28:0] e1, output logic [28:0] e0);
    int mask;
    bit running, frz, fl, h1, h0, s1, s0, wr;
    flight_t n1, n0;
    mask = srcMask(inst);
    running = !m_wait && !m_halt && !m_step;
    frz = m_wait || m_halt || (running && req && !rdy);
    fl = br && !frz;
    h1 = fl1[0].valid && fl1[0].load && (((mask >> fl1[0].dest) & 1) != 0);
    h0 = 0;
    for (int k = 0; k < 2; k++)
      if (fl0[k].valid && (((mask >> fl0[k].dest) & 1) != 0)) h0 = 1;
    s1 = valid && h1 && !fl && !frz;
    s0 = valid && h0 && !fl && !frz;
    e1 = mkExp(s1, fl, tgt, frz, m_halt, cnt1[15:0]);
    e0 = mkExp(s0, fl, tgt, frz, m_halt, cnt0[15:0]);
    if ((s1 || frz) && cnt1 < 65535) cnt1++;
    if ((s0 || frz) && cnt0 < 65535) cnt0++;
    if (!frz) begin
      wr = writesReg(inst);
      n1.valid = valid && !s1 && !fl && wr;
      n0.valid = valid && !s0 && !fl && wr;
      n1.dest = int'(inst[6:4]); n0.dest = n1.dest;
      n1.load = (inst[3:0] == 4'h8); n0.load = n1.load;
      fl1.push_front(n1); fl1.delete(3);
      fl0.push_front(n0); fl0.delete(3);
    end
    if (m_wait) begin
      if (rdy) begin
        m_wait = 0;
        m_halt = halt;
      end
    end else if (m_halt) begin
      if (!halt) m_halt = 0;
      else if (step) begin
        m_halt = 0;
        m_step = 1;
      end
    end else if (m_step) begin
      m_step = 0;
      if (req && !rdy) m_wait = 1;
      else m_halt = halt;
    end else begin
      if (req && !rdy) m_wait = 1;
      else if (halt) m_halt = 1;
    end
  endtask

  initial begin
    logic [28:0] e1, e0;
    logic [15:0] inst;
    logic valid, br, req, rdy, halt, step, prev_step;
    logic [6:0] tgt;

    // inst valid br tgt req rdy halt step | s1 s0 flush frz hlt cnt1 cnt0
    vecs[0]  = '{16'h00B2, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0,  16'd0};
    vecs[1]  = '{16'h01B2, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0,  16'd0};
    vecs[2]  = '{16'h01B2, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0,  16'd1};
    vecs[3]  = '{16'h01B2, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0,  16'd2};
    vecs[4]  = '{16'h02A8, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0,  16'd2};
    vecs[5]  = '{16'h00A1, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0,  16'd2};
    vecs[6]  = '{16'h00A1, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1,  16'd3};
    vecs[7]  = '{16'h0000, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1,  16'd4};
    vecs[8]  = '{16'h02A8, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1,  16'd4};
    vecs[9]  = '{16'h00A1, 1'b1, 1'b1, 7'h2A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1,  16'd4};
    vecs[10] = '{16'h0000, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1,  16'd4};
    vecs[11] = '{16'h00B2, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1,  16'd4};
    vecs[12] = '{16'h01B2, 1'b1, 1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1,  16'd4};
    vecs[13] = '{16'h01B2, 1'b1, 1'b0, 7'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2,  16'd5};
    vecs[14] = '{16'h01B2, 1'b1, 1'b0, 7'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd3,  16'd6};
    vecs[15] = '{16'h01B2, 1'b1, 1'b0, 7'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd4,  16'd7};
    vecs[16] = '{16'h01B2, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd5,  16'd8};
    vecs[17] = '{16'h01B2, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd6,  16'd9};
    vecs[18] = '{16'h01B2, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd7,  16'd10};
    vecs[19] = '{16'h01B2, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd7,  16'd11};
    vecs[20] = '{16'h01B2, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd8,  16'd12};
    vecs[21] = '{16'h01B2, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd9,  16'd13};
    vecs[22] = '{16'h0000, 1'b0, 1'b1, 7'h2A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd9,  16'd14};
    vecs[23] = '{16'h0000, 1'b0, 1'b1, 7'h2A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd10, 16'd15};
    vecs[24] = '{16'h0000, 1'b0, 1'b1, 7'h2A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd11, 16'd16};

    rst_n = 1'b0;
    applyStimulus(16'h0000, 0, 0, 7'h00, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("reset fwd1", got1(), 29'h0);
    checkOutput("reset fwd0", got0(), 29'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      applyStimulus(vecs[i].inst, vecs[i].valid, vecs[i].br, vecs[i].tgt,
                    vecs[i].req, vecs[i].rdy, vecs[i].halt, vecs[i].step);
      @(negedge clk);
      checkOutput($sformatf("row%0d fwd1", i), got1(),
                  mkExp(vecs[i].s1, vecs[i].flush, vecs[i].tgt, vecs[i].frz, vecs[i].hlt, vecs[i].cnt1));
      checkOutput($sformatf("row%0d fwd0", i), got0(),
                  mkExp(vecs[i].s0, vecs[i].flush, vecs[i].tgt, vecs[i].frz, vecs[i].hlt, vecs[i].cnt0));
      @(posedge clk); #1;
    end

    // Asynchronous reset with a load-use hazard live in the scoreboard.
    applyStimulus(16'h02A8, 1, 0, 7'h00, 0, 0, 0, 0);
    @(posedge clk); #1;
    applyStimulus(16'h00A1, 1, 0, 7'h00, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("pre-reset stall fwd1", 29'(got1() >> 27), 29'h3);
    checkOutput("pre-reset stall fwd0", 29'(got0() >> 27), 29'h3);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset fwd1", got1(), 29'h0);
    checkOutput("async reset fwd0", got0(), 29'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(16'h00B2, 1, 0, 7'h00, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("post-reset add fwd1", got1(), 29'h0);
    checkOutput("post-reset add fwd0", got0(), 29'h0);
    @(posedge clk); #1;

    applyStimulus(16'h0000, 0, 0, 7'h00, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    modelReset();
    @(posedge clk); #1;
    rst_n = 1'b1;

    halt = 1'b0;
    prev_step = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 5))
        0: inst[3:0] = 4'h0;
        1: inst[3:0] = 4'h1;
        2: inst[3:0] = 4'h8;
        3: inst[3:0] = ($urandom_range(0, 1) != 0) ? 4'hB : 4'hC;
        default: inst[3:0] = 4'($urandom_range(0, 15));
      endcase
      inst[6:4]   = 3'($urandom_range(0, 3));
      inst[9:7]   = 3'($urandom_range(0, 3));
      inst[15:10] = 6'($urandom);
      valid = ($urandom_range(0, 7) != 0);
      br    = ($urandom_range(0, 7) == 0);
      tgt   = 7'($urandom);
      req   = ($urandom_range(0, 3) == 0);
      rdy   = ($urandom_range(0, 1) != 0);
      if ($urandom_range(0, 19) == 0) halt = ~halt;
      step  = !prev_step && ($urandom_range(0, 5) == 0);
      prev_step = step;
      applyStimulus(inst, valid, br, tgt, req, rdy, halt, step);
      modelCycle(inst, valid, br, tgt, req, rdy, halt, step, e1, e0);
      @(negedge clk);
      checkOutput($sformatf("rand%0d fwd1", c), got1(), e1);
      checkOutput($sformatf("rand%0d fwd0", c), got0(), e0);
      @(posedge clk); #1;
    end

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
